// File: rtl/gb_io_pkg.sv
// Shared I/O register map and timer types for the Game Boy I/O block.
package gb_io_pkg;

    localparam logic [15:0] ADDR_DIV      = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA     = 16'hFF05;
    localparam logic [15:0] ADDR_TMA      = 16'hFF06;
    localparam logic [15:0] ADDR_TAC      = 16'hFF07;
    localparam logic [15:0] ADDR_IF       = 16'hFF0F;
    localparam int unsigned IRQ_TIMER_BIT = 2;

    typedef enum logic [1:0] {RUN, OVF, RELOAD} timer_state_t;

    typedef enum logic [1:0] {RATE_4K, RATE_262K, RATE_65K, RATE_16K} tac_rate_t;

    // Divider bit whose falling edge clocks TIMA for a given rate code.
    function automatic int unsigned rate_bit(tac_rate_t rate);
        case (rate)
            RATE_4K:   return 9;
            RATE_262K: return 3;
            RATE_65K:  return 5;
            default:   return 7;
        endcase
    endfunction

endpackage

// File: rtl/timer_edge_sel.sv
// Selects the TAC-chosen divider bit and detects its falling edge.
module timer_edge_sel
    import gb_io_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic [9:0] cnt,
    input  logic [7:0] TAC,
    output logic       inc_pulse
);

    logic tick;
    logic prev_tick_d;
    logic prev_tick_q;
    logic unused_tac;

    assign unused_tac = ^TAC[7:3];

    // Gate the selected bit with enable; a 1->0 transition of the gated tick is an increment,
    // so disabling the timer or switching rate while the bit is high also counts.
    always_comb begin
        tick        = TAC[2] & cnt[rate_bit(tac_rate_t'(TAC[1:0]))];
        inc_pulse   = prev_tick_q & ~tick;
        prev_tick_d = tick;
    end

    // Remember the previous gated tick.
    always_ff @(posedge clk) begin
        if (!Reset) prev_tick_q <= 1'b0;
        else        prev_tick_q <= prev_tick_d;
    end

endmodule

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA timer: divider counter, TIMA counter with delayed TMA reload and IRQ.
module gb_timer
    import gb_io_pkg::*;
#(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned OVF_DELAY = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        z80_write_n,
    input  logic [15:0] z80_address,
    input  logic [7:0]  z80_dout,
    input  logic [7:0]  TMA,
    input  logic [7:0]  TAC,
    output logic [7:0]  DIV,
    output logic [7:0]  TIMA,
    output logic        timer_irq
);

    localparam int unsigned DLY_W = $clog2(OVF_DELAY + 1);

    logic [DIV_W-1:0] cnt_d, cnt_q;
    logic [7:0]       tima_d, tima_q;
    logic [DLY_W-1:0] dly_d, dly_q;
    logic             irq_d, irq_q;
    timer_state_t     state_d, state_q;
    logic             div_wr, tima_wr, inc_pulse;

    // Exact-address write decode and free-running divider (cleared by any DIV write).
    always_comb begin
        div_wr  = !z80_write_n && (z80_address == ADDR_DIV);
        tima_wr = !z80_write_n && (z80_address == ADDR_TIMA);
        cnt_d   = div_wr ? '0 : cnt_q + DIV_W'(1);
    end

    // Edge detection runs on the post-update count so a DIV clear can produce the quirk increment.
    timer_edge_sel u_edge_sel (
        .clk       (clk),
        .Reset     (Reset),
        .cnt       (cnt_d[9:0]),
        .TAC       (TAC),
        .inc_pulse (inc_pulse)
    );

    // TIMA state machine. TIMA reads 00 for OVF_DELAY cycles after overflow: OVF_DELAY-1 cycles
    // in OVF plus the RELOAD cycle, so TMA and the IRQ become visible together afterwards.
    always_comb begin
        state_d = state_q;
        tima_d  = tima_q;
        dly_d   = dly_q;
        irq_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (tima_wr) begin
                    tima_d = z80_dout;
                end else if (inc_pulse) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = OVF;
                        dly_d   = DLY_W'(OVF_DELAY - 1);
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            OVF: begin
                if (tima_wr) begin
                    tima_d  = z80_dout;
                    state_d = RUN;
                end else if (dly_q <= DLY_W'(1)) begin
                    state_d = RELOAD;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            RELOAD: begin
                tima_d  = TMA;
                irq_d   = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            cnt_q   <= '0;
            tima_q  <= '0;
            dly_q   <= '0;
            irq_q   <= 1'b0;
            state_q <= RUN;
        end else begin
            cnt_q   <= cnt_d;
            tima_q  <= tima_d;
            dly_q   <= dly_d;
            irq_q   <= irq_d;
            state_q <= state_d;
        end
    end

    assign DIV       = cnt_q[DIV_W-1 -: 8];
    assign TIMA      = tima_q;
    assign timer_irq = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
module tb_gb_timer;

    localparam int OVF_DELAY = 4;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        z80_write_n = 1'b1;
    logic [15:0] z80_address = 16'h0000;
    logic [7:0]  z80_dout = 8'h00;
    logic [7:0]  TMA = 8'h00;
    logic [7:0]  TAC = 8'h00;
    logic [7:0]  DIV;
    logic [7:0]  TIMA;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_cnt  = 0;
    bit m_prev = 0;
    int m_tima = 0;
    bit m_irq  = 0;
    int m_age  = -1;   // edges since overflow, -1 when not overflowed

    gb_timer #(.DIV_W(16), .OVF_DELAY(OVF_DELAY)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .z80_write_n (z80_write_n),
        .z80_address (z80_address),
        .z80_dout    (z80_dout),
        .TMA         (TMA),
        .TAC         (TAC),
        .DIV         (DIV),
        .TIMA        (TIMA),
        .timer_irq   (timer_irq)
    );

    always #5 clk = ~clk;

    function automatic bit m_tick(int c, logic [7:0] tac);
        int b;
        case (tac[1:0])
            2'd0:    b = 9;
            2'd1:    b = 3;
            2'd2:    b = 5;
            default: b = 7;
        endcase
        return tac[2] && (((c >> b) & 1) == 1);
    endfunction

    function automatic int m_div();
        return (m_cnt >> 8) & 255;
    endfunction

    task automatic model_step();
        bit wr_div, wr_tima, t, fall;
        if (!Reset) begin
            m_cnt = 0; m_prev = 0; m_tima = 0; m_irq = 0; m_age = -1;
            return;
        end
        wr_div  = !z80_write_n && z80_address == 16'hFF04;
        wr_tima = !z80_write_n && z80_address == 16'hFF05;
        m_cnt   = wr_div ? 0 : (m_cnt + 1) % 65536;
        t       = m_tick(m_cnt, TAC);
        fall    = m_prev && !t;
        m_prev  = t;
        m_irq   = 0;
        if (m_age < 0) begin
            if (wr_tima) m_tima = z80_dout;
            else if (fall) begin
                if (m_tima == 255) begin m_tima = 0; m_age = 0; end
                else m_tima = m_tima + 1;
            end
        end else begin
            m_age = m_age + 1;
            if (m_age == OVF_DELAY) begin
                m_tima = TMA; m_irq = 1; m_age = -1;
            end else if (wr_tima) begin
                m_tima = z80_dout; m_age = -1;
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        z80_write_n = 1'b0; z80_address = a; z80_dout = d;
        clk_step();
        z80_write_n = 1'b1; z80_address = 16'h0000;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        clk_step(); clk_step();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        TAC = 8'h00; TMA = 8'h00;
        do_reset();
        n_checks++; if (DIV !== 8'h00) begin n_fail++; $display("FAIL reset_div got=%h exp=00", DIV); end
        n_checks++; if (TIMA !== 8'h00) begin n_fail++; $display("FAIL reset_tima got=%h exp=00", TIMA); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    endtask

    task automatic test_div();
        TAC = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            clk_step();
            if (i == 255 || i == 511) begin
                n_checks++;
                if (DIV !== 8'(m_div())) begin n_fail++; $display("FAIL div_step got=%h exp=%h", DIV, 8'(m_div())); end
            end
        end
        n_checks++; if (DIV !== 8'h04) begin n_fail++; $display("FAIL div_1024 got=%h exp=04", DIV); end
        n_checks++; if (TIMA !== 8'h00) begin n_fail++; $display("FAIL div_tima got=%h exp=00", TIMA); end
    endtask

    task automatic test_tima_rate();
        do_reset();
        TAC = 8'h05; TMA = 8'h00;
        for (int i = 0; i < 160; i++) clk_step();
        n_checks++; if (TIMA !== 8'h0A) begin n_fail++; $display("FAIL rate_160 got=%h exp=0a", TIMA); end
        n_checks++; if (TIMA !== 8'(m_tima)) begin n_fail++; $display("FAIL rate_model got=%h exp=%h", TIMA, 8'(m_tima)); end
    endtask

    task automatic test_overflow();
        int zeros, irqs;
        bit  saw_f0;
        do_reset();
        TAC = 8'h05; TMA = 8'hF0;
        cpu_write(16'hFF05, 8'hFF);
        zeros = 0; irqs = 0; saw_f0 = 0;
        for (int i = 0; i < 40; i++) begin
            clk_step();
            n_checks++;
            if (TIMA !== 8'(m_tima) || timer_irq !== m_irq) begin
                n_fail++; $display("FAIL ovf_seq cyc=%0d tima=%h irq=%b exp=%h/%b", i, TIMA, timer_irq, 8'(m_tima), m_irq);
            end
            if (TIMA == 8'h00) zeros++;
            if (timer_irq) begin
                irqs++;
                if (TIMA == 8'hF0) saw_f0 = 1;
            end
        end
        n_checks++; if (zeros != OVF_DELAY) begin n_fail++; $display("FAIL ovf_zero_cycles got=%0d exp=%0d", zeros, OVF_DELAY); end
        n_checks++; if (irqs != 1) begin n_fail++; $display("FAIL ovf_irq_count got=%0d exp=1", irqs); end
        n_checks++; if (!saw_f0) begin n_fail++; $display("FAIL ovf_reload got=0 exp=1 (TIMA=f0 with irq)"); end
    endtask

    task automatic test_ovf_abort();
        int irqs, guard;
        do_reset();
        TAC = 8'h05; TMA = 8'hF0;
        cpu_write(16'hFF05, 8'hFF);
        guard = 0;
        while (m_age != 0 && guard < 40) begin clk_step(); guard++; end
        n_checks++; if (m_age != 0) begin n_fail++; $display("FAIL abort_wait got=timeout exp=overflow"); end
        n_checks++; if (TIMA !== 8'h00) begin n_fail++; $display("FAIL abort_ovf_tima got=%h exp=00", TIMA); end
        cpu_write(16'hFF05, 8'h33);
        n_checks++; if (TIMA !== 8'h33) begin n_fail++; $display("FAIL abort_write got=%h exp=33", TIMA); end
        irqs = 0;
        for (int i = 0; i < 30; i++) begin
            clk_step();
            if (timer_irq) irqs++;
            n_checks++;
            if (TIMA !== 8'(m_tima)) begin n_fail++; $display("FAIL abort_run got=%h exp=%h", TIMA, 8'(m_tima)); end
        end
        n_checks++; if (irqs != 0) begin n_fail++; $display("FAIL abort_irq got=%0d exp=0", irqs); end
    endtask

    task automatic test_div_quirk();
        int guard;
        do_reset();
        TAC = 8'h04; TMA = 8'h00;
        guard = 0;
        while (((m_cnt >> 9) & 1) == 0 && guard < 600) begin clk_step(); guard++; end
        n_checks++; if (((m_cnt >> 9) & 1) == 0) begin n_fail++; $display("FAIL quirk_wait got=timeout exp=cnt9"); end
        cpu_write(16'hFF04, 8'h5A);
        n_checks++; if (DIV !== 8'h00) begin n_fail++; $display("FAIL quirk_div got=%h exp=00", DIV); end
        n_checks++; if (TIMA !== 8'h01) begin n_fail++; $display("FAIL quirk_inc got=%h exp=01", TIMA); end
        for (int i = 0; i < 10; i++) clk_step();
        cpu_write(16'hFF04, 8'h00);
        n_checks++; if (TIMA !== 8'h01) begin n_fail++; $display("FAIL quirk_noinc got=%h exp=01", TIMA); end
        n_checks++; if (DIV !== 8'h00) begin n_fail++; $display("FAIL quirk_div2 got=%h exp=00", DIV); end
    endtask

    task automatic test_reset_in_ovf();
        int guard;
        do_reset();
        TAC = 8'h05; TMA = 8'hF0;
        cpu_write(16'hFF05, 8'hFF);
        guard = 0;
        while (m_age != 1 && guard < 40) begin clk_step(); guard++; end
        n_checks++; if (m_age != 1) begin n_fail++; $display("FAIL rstovf_wait got=timeout exp=ovf"); end
        Reset = 1'b0;
        clk_step();
        Reset = 1'b1;
        n_checks++; if (TIMA !== 8'h00 || DIV !== 8'h00) begin n_fail++; $display("FAIL rstovf_regs tima=%h div=%h exp=00/00", TIMA, DIV); end
        for (int i = 0; i < 8; i++) begin
            clk_step();
            n_checks++;
            if (timer_irq !== 1'b0 || TIMA !== 8'h00) begin
                n_fail++; $display("FAIL rstovf_quiet cyc=%0d irq=%b tima=%h exp=0/00", i, timer_irq, TIMA);
            end
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        TAC = 8'h05; TMA = 8'hFE;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            z80_write_n = 1'b1; z80_address = 16'h0000;
            if (r < 8) TAC = 8'($urandom_range(0, 255));
            else if (r < 30) TAC = {5'($urandom), 1'b1, 2'($urandom)};
            if ($urandom_range(0, 49) == 0) TMA = 8'($urandom_range(240, 255));
            r = $urandom_range(0, 999);
            if (r < 30) begin
                z80_write_n = 1'b0; z80_address = 16'hFF05; z80_dout = 8'($urandom_range(250, 255));
            end else if (r < 40) begin
                z80_write_n = 1'b0; z80_address = 16'hFF04; z80_dout = 8'($urandom);
            end else if (r < 60) begin
                z80_write_n = 1'($urandom); z80_address = 16'hFF00 | 16'($urandom_range(0, 15));
                z80_address = (z80_address == 16'hFF05 || z80_address == 16'hFF04) ? {z80_address[15:9], 1'b1, z80_address[7:0]} : z80_address;
                z80_dout = 8'($urandom);
            end else if (r < 80) begin
                z80_write_n = 1'b1; z80_address = 16'hFF05; z80_dout = 8'($urandom);
            end
            Reset = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            clk_step();
            n_checks++;
            if (DIV !== 8'(m_div()) || TIMA !== 8'(m_tima) || timer_irq !== m_irq) begin
                n_fail++;
                $display("FAIL random cyc=%0d div=%h tima=%h irq=%b exp=%h/%h/%b",
                         i, DIV, TIMA, timer_irq, 8'(m_div()), 8'(m_tima), m_irq);
            end
        end
        z80_write_n = 1'b1; Reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_div();
        test_tima_rate();
        test_overflow();
        test_ovf_abort();
        test_div_quirk();
        test_reset_in_ovf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
